id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined RISC-V core; sits directly upstream of the ALU and produces its two operands and 4-bit control code. Registers decoded operands and control, applies EX/MEM and MEM/WB operand forwarding, and holds the EX slot for a fixed number of cycles when a MUL occupies it, so the multiplier path is a multicycle path. Also supplies store data and the memory/writeback control bundle to the EX/MEM register.

---
 rtl/id_ex_stage_if.sv | 68 ++++++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded instruction, forwarding taps, ALU/EX-MEM outputs.
// master drives the *_i side (decode/hazard), slave is the stage itself.
interface id_ex_stage_if #(
  parameter int DATA_W = 32
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [3:0]        alu_ctrl_i;
  logic [DATA_W-1:0] rs1_data_i;
  logic [DATA_W-1:0] rs2_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [4:0]        rs1_addr_i;
  logic [4:0]        rs2_addr_i;
  logic [4:0]        rd_addr_i;
  logic              alu_src_i;
  logic              reg_write_i;
  logic              mem_to_reg_i;
  logic              mem_read_i;
  logic              mem_write_i;
  logic [4:0]        exmem_rd_i;
  logic [4:0]        memwb_rd_i;
  logic              exmem_reg_write_i;
  logic              memwb_reg_write_i;
  logic [DATA_W-1:0] exmem_data_i;
  logic [DATA_W-1:0] memwb_data_i;
  logic [DATA_W-1:0] alu_data1_o;
  logic [DATA_W-1:0] alu_data2_o;
  logic [3:0]        alu_ctrl_o;
  logic [DATA_W-1:0] store_data_o;
  logic [4:0]        rd_addr_o;
  logic              reg_write_o;
  logic              mem_to_reg_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic              valid_o;
  logic              busy_o;

  modport master (
    output stall_i, flush_i, valid_i, alu_ctrl_i,
    output rs1_data_i, rs2_data_i, imm_i,
    output rs1_addr_i, rs2_addr_i, rd_addr_i,
    output alu_src_i, reg_write_i, mem_to_reg_i,
    output mem_read_i, mem_write_i,
    output exmem_rd_i, memwb_rd_i,
    output exmem_reg_write_i, memwb_reg_write_i,
    output exmem_data_i, memwb_data_i,
    input  alu_data1_o, alu_data2_o, alu_ctrl_o,
    input  store_data_o, rd_addr_o, reg_write_o,
    input  mem_to_reg_o, mem_read_o, mem_write_o,
    input  valid_o, busy_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, alu_ctrl_i,
    input  rs1_data_i, rs2_data_i, imm_i,
    input  rs1_addr_i, rs2_addr_i, rd_addr_i,
    input  alu_src_i, reg_write_i, mem_to_reg_i,
    input  mem_read_i, mem_write_i,
    input  exmem_rd_i, memwb_rd_i,
    input  exmem_reg_write_i, memwb_reg_write_i,
    input  exmem_data_i, memwb_data_i,
    output alu_data1_o, alu_data2_o, alu_ctrl_o,
    output store_data_o, rd_addr_o, reg_write_o,
    output mem_to_reg_o, mem_read_o, mem_write_o,
    output valid_o, busy_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX register with operand forwarding and multicycle MUL hold.
// ID_EX_FORWARD_EN builds the forwarding muxes and hold-time refresh.
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input logic         clk_i,
  input logic         rst_i,
  id_ex_stage_if.slave bus
);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [3:0] OP_MUL = 4'b0101;

  logic              valid_q;
  logic [3:0]        ctrl_q;
  logic [DATA_W-1:0] rs1_q;
  logic [DATA_W-1:0] rs2_q;
  logic [DATA_W-1:0] imm_q;
  logic [4:0]        rs1a_q;
  logic [4:0]        rs2a_q;
  logic [4:0]        rd_q;
  logic              alu_src_q;
  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [CW-1:0]     cnt_q;

  logic              busy;
  logic              cap;
  logic              is_mul;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;

  assign busy   = (cnt_q != '0);
  assign cap    = bus.valid_i;
  assign is_mul = bus.valid_i && (bus.alu_ctrl_i == OP_MUL);

`ifdef ID_EX_FORWARD_EN
  logic ex_hit1, ex_hit2, wb_hit1, wb_hit2;

  always_comb begin
    ex_hit1 = bus.exmem_reg_write_i && (bus.exmem_rd_i != 5'd0)
              && (bus.exmem_rd_i == rs1a_q);
    ex_hit2 = bus.exmem_reg_write_i && (bus.exmem_rd_i != 5'd0)
              && (bus.exmem_rd_i == rs2a_q);
    wb_hit1 = bus.memwb_reg_write_i && (bus.memwb_rd_i != 5'd0)
              && (bus.memwb_rd_i == rs1a_q);
    wb_hit2 = bus.memwb_reg_write_i && (bus.memwb_rd_i != 5'd0)
              && (bus.memwb_rd_i == rs2a_q);
    fwd1 = rs1_q;
    fwd2 = rs2_q;
    unique case (1'b1)
      ex_hit1: fwd1 = bus.exmem_data_i;
      wb_hit1: fwd1 = bus.memwb_data_i;
      default: fwd1 = rs1_q;
    endcase
    unique case (1'b1)
      ex_hit2: fwd2 = bus.exmem_data_i;
      wb_hit2: fwd2 = bus.memwb_data_i;
      default: fwd2 = rs2_q;
    endcase
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{bus.exmem_rd_i, bus.memwb_rd_i,
                        bus.exmem_reg_write_i, bus.memwb_reg_write_i,
                        bus.exmem_data_i, bus.memwb_data_i};
  assign fwd1 = rs1_q;
  assign fwd2 = rs2_q;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q      <= 1'b0;
      ctrl_q       <= 4'd0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      rs1a_q       <= 5'd0;
      rs2a_q       <= 5'd0;
      rd_q         <= 5'd0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      cnt_q        <= '0;
    end else if (bus.flush_i) begin
      valid_q      <= 1'b0;
      ctrl_q       <= 4'd0;
      rs1_q        <= bus.rs1_data_i;
      rs2_q        <= bus.rs2_data_i;
      imm_q        <= bus.imm_i;
      rs1a_q       <= bus.rs1_addr_i;
      rs2a_q       <= bus.rs2_addr_i;
      rd_q         <= 5'd0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      cnt_q        <= '0;
    end else if (busy || bus.stall_i) begin
      if (busy)
        cnt_q <= cnt_q - 1'b1;
`ifdef ID_EX_FORWARD_EN
      // latch forwarded values so they outlive the producer
      rs1_q <= fwd1;
      rs2_q <= fwd2;
`endif
    end else begin
      valid_q      <= cap;
      ctrl_q       <= cap ? bus.alu_ctrl_i : 4'd0;
      rs1_q        <= bus.rs1_data_i;
      rs2_q        <= bus.rs2_data_i;
      imm_q        <= bus.imm_i;
      rs1a_q       <= bus.rs1_addr_i;
      rs2a_q       <= bus.rs2_addr_i;
      rd_q         <= cap ? bus.rd_addr_i : 5'd0;
      alu_src_q    <= cap & bus.alu_src_i;
      reg_write_q  <= cap & bus.reg_write_i;
      mem_to_reg_q <= cap & bus.mem_to_reg_i;
      mem_read_q   <= cap & bus.mem_read_i;
      mem_write_q  <= cap & bus.mem_write_i;
      cnt_q        <= is_mul ? CW'(MUL_LAT - 1) : '0;
    end
  end

  assign bus.alu_data1_o  = fwd1;
  assign bus.alu_data2_o  = alu_src_q ? imm_q : fwd2;
  assign bus.store_data_o = fwd2;
  assign bus.alu_ctrl_o   = ctrl_q;
  assign bus.rd_addr_o    = rd_q;
  assign bus.reg_write_o  = reg_write_q;
  assign bus.mem_to_reg_o = mem_to_reg_q;
  assign bus.mem_read_o   = mem_read_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.busy_o       = busy;
  assign bus.valid_o      = valid_q & ~busy;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (MUL_LAT=3).
// Forwarding expectations follow whether ID_EX_FORWARD_EN is defined.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   cmp;
  int   bad;

  id_ex_stage_if #(.DATA_W(32)) bus ();

  id_ex_stage #(.DATA_W(32), .MUL_LAT(3)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] rd,
                       input logic src, input logic rw);
    bus.valid_i      = v;
    bus.alu_ctrl_i   = op;
    bus.rs1_data_i   = d1;
    bus.rs2_data_i   = d2;
    bus.imm_i        = imm;
    bus.rs1_addr_i   = a1;
    bus.rs2_addr_i   = a2;
    bus.rd_addr_i    = rd;
    bus.alu_src_i    = src;
    bus.reg_write_i  = rw;
    bus.mem_to_reg_i = 1'b0;
    bus.mem_read_i   = 1'b0;
    bus.mem_write_i  = 1'b0;
  endtask

  task automatic clear_fwd();
    bus.exmem_rd_i        = 5'd0;
    bus.memwb_rd_i        = 5'd0;
    bus.exmem_reg_write_i = 1'b0;
    bus.memwb_reg_write_i = 1'b0;
    bus.exmem_data_i      = 32'h0;
    bus.memwb_data_i      = 32'h0;
  endtask

  task automatic test_reset();
    cmp++;
    if (bus.alu_data1_o !== 32'h0) begin
      bad++;
      $display("FAIL rst_data1 got %h want 0", bus.alu_data1_o);
    end
    cmp++;
    if (bus.alu_data2_o !== 32'h0) begin
      bad++;
      $display("FAIL rst_data2 got %h want 0", bus.alu_data2_o);
    end
    cmp++;
    if (bus.alu_ctrl_o !== 4'h0) begin
      bad++;
      $display("FAIL rst_ctrl got %h want 0", bus.alu_ctrl_o);
    end
    cmp++;
    if ({bus.valid_o, bus.busy_o} !== 2'b00) begin
      bad++;
      $display("FAIL rst_vb got %b want 00", {bus.valid_o, bus.busy_o});
    end
  endtask

  task automatic test_add();
    drive(1, 4'b0011, 5, 7, 0, 1, 2, 4, 0, 1);
    tick();
    cmp++;
    if (bus.alu_data1_o !== 32'd5 || bus.alu_data2_o !== 32'd7) begin
      bad++;
      $display("FAIL add_ops got %0d/%0d want 5/7",
               bus.alu_data1_o, bus.alu_data2_o);
    end
    cmp++;
    if ({bus.valid_o, bus.busy_o} !== 2'b10) begin
      bad++;
      $display("FAIL add_vb got %b want 10", {bus.valid_o, bus.busy_o});
    end
    cmp++;
    if (bus.alu_ctrl_o !== 4'b0011 || bus.rd_addr_o !== 5'd4
        || bus.reg_write_o !== 1'b1) begin
      bad++;
      $display("FAIL add_ctl got %h/%0d/%b want 3/4/1",
               bus.alu_ctrl_o, bus.rd_addr_o, bus.reg_write_o);
    end
  endtask

  task automatic test_forward();
    logic [31:0] exp;
    drive(1, 4'b0011, 32'h99, 32'h1, 0, 3, 0, 6, 0, 1);
    tick();
    bus.exmem_rd_i        = 5'd3;
    bus.exmem_data_i      = 32'h10;
    bus.exmem_reg_write_i = 1'b1;
    bus.memwb_rd_i        = 5'd3;
    bus.memwb_data_i      = 32'h20;
    bus.memwb_reg_write_i = 1'b1;
    #1;
    exp = FWD ? 32'h10 : 32'h99;
    cmp++;
    if (bus.alu_data1_o !== exp) begin
      bad++;
      $display("FAIL fwd_exmem got %h want %h", bus.alu_data1_o, exp);
    end
    bus.exmem_reg_write_i = 1'b0;
    #1;
    exp = FWD ? 32'h20 : 32'h99;
    cmp++;
    if (bus.alu_data1_o !== exp) begin
      bad++;
      $display("FAIL fwd_memwb got %h want %h", bus.alu_data1_o, exp);
    end
    drive(1, 4'b0011, 32'h77, 32'h1, 0, 0, 0, 6, 0, 1);
    bus.exmem_rd_i        = 5'd0;
    bus.exmem_reg_write_i = 1'b1;
    bus.memwb_rd_i        = 5'd0;
    bus.memwb_reg_write_i = 1'b1;
    tick();
    cmp++;
    if (bus.alu_data1_o !== 32'h77) begin
      bad++;
      $display("FAIL fwd_x0 got %h want 77", bus.alu_data1_o);
    end
    clear_fwd();
  endtask

  task automatic test_mul();
    drive(1, 4'b0101, 6, 7, 0, 5, 6, 7, 0, 1);
    tick();
    drive(1, 4'b0011, 1, 2, 0, 10, 11, 8, 0, 1);
    for (int c = 1; c <= 2; c++) begin
      cmp++;
      if ({bus.valid_o, bus.busy_o} !== 2'b01) begin
        bad++;
        $display("FAIL mul_hold%0d got %b want 01",
                 c, {bus.valid_o, bus.busy_o});
      end
      tick();
    end
    cmp++;
    if ({bus.valid_o, bus.busy_o} !== 2'b10 || bus.alu_ctrl_o !== 4'b0101
        || bus.alu_data1_o !== 32'd6 || bus.alu_data2_o !== 32'd7) begin
      bad++;
      $display("FAIL mul_done got vb=%b op=%h %0d/%0d want 10 5 6/7",
               {bus.valid_o, bus.busy_o}, bus.alu_ctrl_o,
               bus.alu_data1_o, bus.alu_data2_o);
    end
    tick();
    cmp++;
    if (bus.alu_ctrl_o !== 4'b0011 || bus.alu_data1_o !== 32'd1
        || bus.rd_addr_o !== 5'd8 || bus.valid_o !== 1'b1) begin
      bad++;
      $display("FAIL mul_next got op=%h d1=%0d rd=%0d v=%b want 3 1 8 1",
               bus.alu_ctrl_o, bus.alu_data1_o, bus.rd_addr_o, bus.valid_o);
    end
  endtask

  task automatic test_mul_fwd_hold();
    logic [31:0] exp;
    exp = FWD ? 32'h55 : 32'h3;
    drive(1, 4'b0101, 2, 3, 0, 8, 9, 12, 0, 1);
    tick();
    drive(1, 4'b0011, 0, 0, 0, 0, 0, 13, 0, 1);
    bus.exmem_rd_i        = 5'd9;
    bus.exmem_data_i      = 32'h55;
    bus.exmem_reg_write_i = 1'b1;
    #1;
    cmp++;
    if (bus.alu_data2_o !== exp) begin
      bad++;
      $display("FAIL mfh_c1 got %h want %h", bus.alu_data2_o, exp);
    end
    tick();
    clear_fwd();
    #1;
    cmp++;
    if (bus.alu_data2_o !== exp) begin
      bad++;
      $display("FAIL mfh_c2 got %h want %h", bus.alu_data2_o, exp);
    end
    tick();
    cmp++;
    if (bus.alu_data2_o !== exp || bus.valid_o !== 1'b1) begin
      bad++;
      $display("FAIL mfh_c3 got %h v=%b want %h v=1",
               bus.alu_data2_o, bus.valid_o, exp);
    end
    tick();
  endtask

  task automatic test_flush();
    drive(1, 4'b0101, 4, 4, 0, 1, 2, 3, 0, 1);
    tick();
    bus.flush_i = 1'b1;
    bus.stall_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    cmp++;
    if ({bus.valid_o, bus.busy_o} !== 2'b00 || bus.alu_ctrl_o !== 4'h0
        || bus.rd_addr_o !== 5'd0 || bus.reg_write_o !== 1'b0) begin
      bad++;
      $display("FAIL flush got vb=%b op=%h rd=%0d rw=%b want 00 0 0 0",
               {bus.valid_o, bus.busy_o}, bus.alu_ctrl_o,
               bus.rd_addr_o, bus.reg_write_o);
    end
  endtask

  task automatic test_addi();
    drive(1, 4'b0110, 10, 32'h123, 32'hFFFF_FFFC, 1, 2, 5, 1, 1);
    tick();
    cmp++;
    if (bus.alu_data2_o !== 32'hFFFF_FFFC || bus.alu_data1_o !== 32'd10) begin
      bad++;
      $display("FAIL addi got %h/%h want 0000000a/fffffffc",
               bus.alu_data1_o, bus.alu_data2_o);
    end
    cmp++;
    if (bus.store_data_o !== 32'h123) begin
      bad++;
      $display("FAIL addi_store got %h want 123", bus.store_data_o);
    end
  endtask

  task automatic test_stall();
    bus.stall_i = 1'b1;
    drive(1, 4'b0001, 9, 9, 0, 1, 2, 20, 0, 1);
    for (int c = 0; c < 2; c++) begin
      tick();
      cmp++;
      if (bus.alu_ctrl_o !== 4'b0110 || bus.valid_o !== 1'b1
          || bus.rd_addr_o !== 5'd5) begin
        bad++;
        $display("FAIL stall%0d got op=%h v=%b rd=%0d want 6 1 5",
                 c, bus.alu_ctrl_o, bus.valid_o, bus.rd_addr_o);
      end
    end
    bus.stall_i = 1'b0;
    tick();
    cmp++;
    if (bus.alu_ctrl_o !== 4'b0001 || bus.rd_addr_o !== 5'd20) begin
      bad++;
      $display("FAIL stall_rel got op=%h rd=%0d want 1 20",
               bus.alu_ctrl_o, bus.rd_addr_o);
    end
  endtask

  task automatic test_bubble();
    drive(0, 4'b0011, 1, 1, 0, 1, 1, 5, 1, 1);
    tick();
    cmp++;
    if (bus.valid_o !== 1'b0 || bus.alu_ctrl_o !== 4'h0
        || bus.rd_addr_o !== 5'd0 || bus.reg_write_o !== 1'b0) begin
      bad++;
      $display("FAIL bubble got v=%b op=%h rd=%0d rw=%b want 0 0 0 0",
               bus.valid_o, bus.alu_ctrl_o, bus.rd_addr_o, bus.reg_write_o);
    end
  endtask

  task automatic test_reset_mid_mul();
    drive(1, 4'b0101, 3, 3, 0, 1, 2, 9, 0, 1);
    tick();
    tick();
    cmp++;
    if (bus.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL rmm_busy got %b want 1", bus.busy_o);
    end
    rst_n = 1'b0;
    #1;
    test_reset();
    #2;
    rst_n = 1'b1;
    drive(1, 4'b0011, 5, 7, 0, 1, 2, 4, 0, 1);
    tick();
    cmp++;
    if (bus.alu_data1_o !== 32'd5 || bus.valid_o !== 1'b1
        || bus.busy_o !== 1'b0 || bus.alu_ctrl_o !== 4'b0011) begin
      bad++;
      $display("FAIL rmm_add got d1=%0d v=%b b=%b op=%h want 5 1 0 3",
               bus.alu_data1_o, bus.valid_o, bus.busy_o, bus.alu_ctrl_o);
    end
  endtask

  initial begin
    cmp = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    drive(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_fwd();
    #12;
    test_reset();
    rst_n = 1'b1;
    test_add();
    test_forward();
    test_mul();
    test_mul_fwd_hold();
    test_flush();
    test_addi();
    test_stall();
    test_bubble();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
